opponent_sync: RTL and testbench
================================

OPPONENT_SYNC -- requirements
Module: opponent_sync

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5_000_000, meaning link-loss timeout in clk_in cycles (100 ms at 50 MHz).
REQ-003 SHALL have parameter X_MAX, default 1023, meaning largest legal opponent x.
REQ-004 SHALL have parameter Y_MAX, default 767, meaning largest legal opponent y.
REQ-005 SHALL have parameter DIR_MAX, default 359, meaning largest legal direction.
REQ-006 SHALL have port clk_in, input, 1, eth_refclk domain clock.
REQ-007 SHALL have port rst_in_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port axiiv, input, 1, a one-cycle strobe marking a received packet on axiid.
REQ-009 SHALL have port axiid, input, 44, the received packet: x=[43:33], y=[31:21], dir=[19:11], game=[7:5], reset flag=[3]; other bits are ignored.
REQ-010 SHALL have ports opp_x and opp_y, output, 11 each, and opp_dir, output, 9, holding the last accepted opponent position and heading.
REQ-011 SHALL have port opp_game, output, 3, holding the last accepted game status.
REQ-012 SHALL have port opp_valid, output, 1, high once any packet has been accepted since reset.
REQ-013 SHALL have port opp_reset_pulse, output, 1, a one-cycle request for the remote reset.
REQ-014 SHALL have port link_up, output, 1, high while the link FSM is in state UP.
REQ-015 SHALL have ports pkt_count, output, 16, counting accepted packets, and drop_count, output, 8, counting rejected packets.

Function
REQ-016 SHALL, on an axiiv strobe, reject the packet if axiid==0, x>X_MAX, y>Y_MAX, or dir>DIR_MAX; otherwise it SHALL accept it.
REQ-017 SHALL update opp_x, opp_y, opp_dir, opp_game and opp_valid exactly one cycle after the strobe of an accepted packet; rejected packets SHALL leave them unchanged.
REQ-018 SHALL count, for link purposes, a packet identical to the previous accepted packet as accepted (keepalive); its outputs SHALL be unchanged in value.
REQ-019 SHALL treat the reset flag as debounced: opp_reset_pulse SHALL pulse for one cycle, one cycle after the strobe of the second consecutive accepted packet with flag=1.
REQ-020 SHALL clear the debounce streak on any accepted packet with flag=0; a third or later consecutive flag=1 packet SHALL NOT pulse again until the streak has been broken.
REQ-021 SHALL not allow rejected packets to affect the debounce streak.
REQ-022 SHALL implement the link FSM with states DOWN (reset state), UP and STALE.
REQ-023 SHALL move to UP on an accepted packet from DOWN or STALE; in that case the idle counter SHALL be cleared to 0.
REQ-024 SHALL, in UP, increment the idle counter every cycle with no accepted packet; when the counter reaches TIMEOUT_CYCLES-1 it SHALL go to STALE.
REQ-025 SHALL keep opp_* outputs and opp_valid unchanged in STALE, with link_up=0.
REQ-026 SHALL saturate the idle counter and SHALL NOT wrap it.
REQ-027 SHALL, when an accepted strobe and the timeout terminal count coincide, make the accept win: the state stays UP and the counter is cleared.
REQ-028 SHALL increment pkt_count on each accepted packet and wrap it from 0xFFFF to 0.
REQ-029 SHALL increment drop_count on each rejected packet and saturate it at 0xFF.

Reset
REQ-030 SHALL, with rst_in_n=0 at a clock edge, set every output, the debounce streak, the idle counter, the counters and the stored previous packet to 0, and the FSM to DOWN.
REQ-031 SHALL, on a reset asserted in the same cycle as axiiv, take the reset and discard the packet.

Configuration
REQ-032 SHALL, with macro OPP_SYNC_STATS_EN defined, implement pkt_count and drop_count as specified.
REQ-033 SHALL, without OPP_SYNC_STATS_EN, omit both counter registers and tie pkt_count and drop_count to constant 0; all other behaviour SHALL be identical.

Verification
REQ-034 SHALL cover: reset, then strobe axiid with x=100, y=200, dir=90, game=1 -> opp_x=100, opp_y=200, opp_dir=90, opp_game=1, opp_valid=1 and link_up=1 one cycle later.
REQ-035 SHALL cover: strobe x=1024, then strobe axiid=0 -> outputs unchanged, drop_count=2, pkt_count unchanged.
REQ-036 SHALL cover: three consecutive valid packets with flag=1 -> exactly one opp_reset_pulse, one cycle after the second; then flag=0 followed by two flag=1 packets -> exactly one more pulse.
REQ-037 SHALL cover, with TIMEOUT_CYCLES=16: accept, then 16 idle cycles -> link_up falls and opp_valid stays 1; then a further accept -> link_up=1 one cycle later.
REQ-038 SHALL cover, with TIMEOUT_CYCLES=16: an accept landing on the terminal-count cycle -> link_up never drops.
REQ-039 SHALL cover: 300 invalid strobes -> drop_count=255, and both counters read 0 in a build without OPP_SYNC_STATS_EN.

Source files
------------

// File: rtl/opponent_sync.sv
// rtl/opponent_sync.sv - opponent packet receiver: validation, reset-flag debounce, link-loss FSM
// Define OPP_SYNC_STATS_EN to build the pkt_count/drop_count statistics registers.
module opponent_sync #(
   parameter int TIMEOUT_CYCLES = 5_000_000,
   parameter int X_MAX          = 1023,
   parameter int Y_MAX          = 767,
   parameter int DIR_MAX        = 359
) (
   input  logic        clk_in,
   input  logic        rst_in_n,
   input  logic        axiiv,
   input  logic [43:0] axiid,
   output logic [10:0] opp_x,
   output logic [10:0] opp_y,
   output logic [8:0]  opp_dir,
   output logic [2:0]  opp_game,
   output logic        opp_valid,
   output logic        opp_reset_pulse,
   output logic        link_up,
   output logic [15:0] pkt_count,
   output logic [7:0]  drop_count
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [10:0] X_LIM   = 11'(X_MAX);
   localparam logic [10:0] Y_LIM   = 11'(Y_MAX);
   localparam logic [8:0]  DIR_LIM = 9'(DIR_MAX);

   typedef enum logic [1:0] {DOWN, UP, STALE} link_state_t;
   typedef enum logic [1:0] {STREAK_NONE, STREAK_ONE, STREAK_DONE} streak_t;

   logic [10:0] pkt_x;
   logic [10:0] pkt_y;
   logic [8:0]  pkt_dir;
   logic [2:0]  pkt_game;
   logic        pkt_flag;
   logic        accept;
   logic        keepalive;
   logic [43:0] prev_pkt;
   link_state_t state;
   streak_t     streak;
   logic [CNT_W-1:0] idle_count;

   assign pkt_x    = axiid[43:33];
   assign pkt_y    = axiid[31:21];
   assign pkt_dir  = axiid[19:11];
   assign pkt_game = axiid[7:5];
   assign pkt_flag = axiid[3];
   assign accept   = axiiv && (axiid != '0) && (pkt_x <= X_LIM) && (pkt_y <= Y_LIM)
                     && (pkt_dir <= DIR_LIM);
   assign keepalive = (axiid == prev_pkt);

   always_ff @(posedge clk_in) begin
      if (!rst_in_n) begin
         opp_x           <= '0;
         opp_y           <= '0;
         opp_dir         <= '0;
         opp_game        <= '0;
         opp_valid       <= 1'b0;
         opp_reset_pulse <= 1'b0;
         link_up         <= 1'b0;
         prev_pkt        <= '0;
         streak          <= STREAK_NONE;
         state           <= DOWN;
         idle_count      <= '0;
      end else begin
         opp_reset_pulse <= 1'b0;
         if (accept) begin
            prev_pkt  <= axiid;
            opp_valid <= 1'b1;
            if (!keepalive) begin
               opp_x    <= pkt_x;
               opp_y    <= pkt_y;
               opp_dir  <= pkt_dir;
               opp_game <= pkt_game;
            end
            // STREAK_DONE holds until a flag=0 packet re-arms the debounce
            if (pkt_flag) begin
               if (streak == STREAK_NONE) begin
                  streak <= STREAK_ONE;
               end else if (streak == STREAK_ONE) begin
                  streak          <= STREAK_DONE;
                  opp_reset_pulse <= 1'b1;
               end
            end else begin
               streak <= STREAK_NONE;
            end
         end

         case (state)
            DOWN, STALE: begin
               if (accept) begin
                  state      <= UP;
                  link_up    <= 1'b1;
                  idle_count <= '0;
               end
            end
            UP: begin
               if (accept) begin
                  idle_count <= '0;
               end else if (idle_count == IDLE_LAST) begin
                  state   <= STALE;
                  link_up <= 1'b0;
               end else begin
                  idle_count <= idle_count + 1'b1;
               end
            end
            default: begin
               state   <= DOWN;
               link_up <= 1'b0;
            end
         endcase
      end
   end

`ifdef OPP_SYNC_STATS_EN
   always_ff @(posedge clk_in) begin
      if (!rst_in_n) begin
         pkt_count  <= '0;
         drop_count <= '0;
      end else if (axiiv) begin
         if (accept) begin
            pkt_count <= pkt_count + 1'b1;
         end else if (drop_count != 8'hFF) begin
            drop_count <= drop_count + 1'b1;
         end
      end
   end
`else
   assign pkt_count  = '0;
   assign drop_count = '0;
`endif

endmodule

// File: tb/tb_opponent_sync.sv
// tb/tb_opponent_sync.sv - randomized scoreboard bench for opponent_sync
// Directed scenarios first, then random traffic; a monitor compares every cycle.
module tb_opponent_sync;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        axiiv = 1'b0;
   logic [43:0] axiid = '0;
   logic [10:0] opp_x;
   logic [10:0] opp_y;
   logic [8:0]  opp_dir;
   logic [2:0]  opp_game;
   logic        opp_valid;
   logic        opp_reset_pulse;
   logic        link_up;
   logic [15:0] pkt_count;
   logic [7:0]  drop_count;

   always #5 clk = ~clk;

   opponent_sync #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_in(clk), .rst_in_n(rst_n), .axiiv(axiiv), .axiid(axiid),
      .opp_x(opp_x), .opp_y(opp_y), .opp_dir(opp_dir), .opp_game(opp_game),
      .opp_valid(opp_valid), .opp_reset_pulse(opp_reset_pulse), .link_up(link_up),
      .pkt_count(pkt_count), .drop_count(drop_count)
   );

   typedef struct {
      logic [10:0] x;
      logic [10:0] y;
      logic [8:0]  dir;
      logic [2:0]  game;
      logic        valid;
      logic        pulse;
      logic        link;
      logic [15:0] pc;
      logic [7:0]  dc;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int cycle = 0;

   // reference model state
   int m_x, m_y, m_dir, m_game, m_streak, m_idle, m_pc, m_dc;
   bit m_valid, m_pulse, m_seen;
   logic [43:0] last_sent = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle, act, expv);
      end
   endtask

   function automatic logic [43:0] mk(input int x, input int y, input int dir, input int game,
                                      input int flag, input int junk);
      logic [43:0] d;
      d = '0;
      d[43:33] = x[10:0];
      d[31:21] = y[10:0];
      d[19:11] = dir[8:0];
      d[7:5]   = game[2:0];
      d[3]     = flag[0];
      d[32]    = junk[0];
      d[20]    = junk[1];
      d[10:8]  = junk[4:2];
      d[4]     = junk[5];
      d[2:0]   = junk[8:6];
      return d;
   endfunction

   task automatic model(input bit r, input bit v, input logic [43:0] d, output exp_t e);
      int fx, fy, fd;
      bit acc;
      if (!r) begin
         m_x = 0; m_y = 0; m_dir = 0; m_game = 0; m_valid = 0; m_pulse = 0;
         m_streak = 0; m_seen = 0; m_idle = 0; m_pc = 0; m_dc = 0;
      end else begin
         fx = int'(d[43:33]);
         fy = int'(d[31:21]);
         fd = int'(d[19:11]);
         acc = v && (d != 0) && fx <= 1023 && fy <= 767 && fd <= 359;
         m_pulse = 0;
         if (acc) begin
            m_x = fx; m_y = fy; m_dir = fd; m_game = int'(d[7:5]);
            m_valid = 1; m_seen = 1; m_idle = 0;
            m_pc = (m_pc + 1) % 65536;
            if (d[3]) begin
               m_streak = (m_streak < 3) ? m_streak + 1 : 3;
               m_pulse = (m_streak == 2);
            end else begin
               m_streak = 0;
            end
         end else begin
            if (v) m_dc = (m_dc < 255) ? m_dc + 1 : 255;
            if (m_seen && m_idle < 1000000) m_idle++;
         end
      end
      e.x = m_x[10:0]; e.y = m_y[10:0]; e.dir = m_dir[8:0]; e.game = m_game[2:0];
      e.valid = m_valid; e.pulse = m_pulse;
      e.link = m_seen && (m_idle < TO);
`ifdef OPP_SYNC_STATS_EN
      e.pc = m_pc[15:0]; e.dc = m_dc[7:0];
`else
      e.pc = '0; e.dc = '0;
`endif
   endtask

   task automatic drive(input bit r, input bit v, input logic [43:0] d);
      exp_t e;
      @(negedge clk);
      rst_n = r; axiiv = v; axiid = d;
      if (v) last_sent = d;
      model(r, v, d, e);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, mk(int'($urandom), int'($urandom), 0, 0, 0, 0));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk); #1;
         cycle++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("opp_x", 64'(opp_x), 64'(e.x));
            chk("opp_y", 64'(opp_y), 64'(e.y));
            chk("opp_dir", 64'(opp_dir), 64'(e.dir));
            chk("opp_game", 64'(opp_game), 64'(e.game));
            chk("opp_valid", 64'(opp_valid), 64'(e.valid));
            chk("opp_reset_pulse", 64'(opp_reset_pulse), 64'(e.pulse));
            chk("link_up", 64'(link_up), 64'(e.link));
            chk("pkt_count", 64'(pkt_count), 64'(e.pc));
            chk("drop_count", 64'(drop_count), 64'(e.dc));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog cycle=%0d actual=running expected=finished", cycle);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int r, k;
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0);

      drive(1'b1, 1'b1, mk(100, 200, 90, 1, 0, 0));
      idle(1);
      drive(1'b1, 1'b1, mk(1024, 5, 5, 0, 0, 0));
      drive(1'b1, 1'b1, '0);
      idle(1);

      // flag debounce: three flag=1, then flag=0 and two flag=1 with a reject in between
      drive(1'b1, 1'b1, mk(10, 10, 10, 2, 1, 0));
      drive(1'b1, 1'b1, mk(11, 11, 11, 2, 1, 0));
      drive(1'b1, 1'b1, mk(12, 12, 12, 2, 1, 0));
      drive(1'b1, 1'b1, mk(13, 13, 13, 3, 0, 0));
      drive(1'b1, 1'b1, mk(14, 14, 14, 3, 1, 0));
      drive(1'b1, 1'b1, mk(14, 800, 14, 3, 0, 0));
      drive(1'b1, 1'b1, mk(15, 15, 15, 3, 1, 0));
      idle(2);

      // timeout then recovery, then accept on the terminal-count cycle
      drive(1'b1, 1'b1, mk(1023, 767, 359, 7, 0, 0));
      idle(TO + 3);
      drive(1'b1, 1'b1, mk(1, 2, 3, 4, 0, 0));
      idle(TO - 1);
      drive(1'b1, 1'b1, mk(5, 6, 7, 0, 0, 0));
      idle(TO - 1);
      drive(1'b1, 1'b1, mk(5, 6, 7, 0, 0, 0));
      idle(3);

      for (int i = 0; i < 300; i++) begin
         case (i % 4)
            0: drive(1'b1, 1'b1, mk(1024 + i, 0, 0, 0, 0, 0));
            1: drive(1'b1, 1'b1, mk(0, 768, 0, 0, 0, 0));
            2: drive(1'b1, 1'b1, mk(0, 0, 360, 0, 0, 0));
            default: drive(1'b1, 1'b1, '0);
         endcase
      end
      idle(2);

      drive(1'b0, 1'b1, mk(1, 1, 1, 1, 0, 0));
      idle(2);

      for (int n = 0; n < 4000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 1) begin
            drive(1'b0, 1'(r), mk(int'($urandom_range(0, 1023)), 3, 3, 1, 0, 0));
         end else if (r < 4) begin
            idle(int'($urandom_range(10, 25)));
         end else if (r < 40) begin
            idle(1);
         end else begin
            k = int'($urandom_range(0, 11));
            case (k)
               0: drive(1'b1, 1'b1, '0);
               1: drive(1'b1, 1'b1, last_sent);
               2: drive(1'b1, 1'b1, mk(int'($urandom_range(1024, 2047)), 1, 1, 1, 1, 0));
               3: drive(1'b1, 1'b1, mk(1, int'($urandom_range(768, 2047)), 1, 1, 1, 0));
               4: drive(1'b1, 1'b1, mk(1, 1, int'($urandom_range(360, 511)), 1, 1, 0));
               5: drive(1'b1, 1'b1, mk(1023, 767, 359, int'($urandom_range(0, 7)),
                                       int'($urandom_range(0, 1)), 0));
               default: drive(1'b1, 1'b1, mk(int'($urandom_range(0, 1023)),
                                             int'($urandom_range(0, 767)),
                                             int'($urandom_range(0, 359)),
                                             int'($urandom_range(0, 7)),
                                             int'($urandom_range(0, 1)),
                                             int'($urandom_range(0, 511))));
            endcase
         end
      end
      idle(2);
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
